store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter DEPTH, default 2, number of write-buffer entries; legal values 2 or 4.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous reset, active-high.
REQ-004 valid_i  input  1  store request presented this cycle.
REQ-005 itype_i  input  5  instruction type; a store is decoded only when it equals `STYPE from itype.v.
REQ-006 ir_i  input  32  instruction word; store width is taken from funct3 = ir_i[14:12].
REQ-007 y_in  input  32  effective byte address from the ALU.
REQ-008 pass_in  input  32  store source register value.
REQ-009 stall_o  output  1  buffer full; the pipeline holds the request.
REQ-010 misalign_o  output  1  one-cycle pulse for a rejected misaligned store.
REQ-011 empty_o  output  1  buffer empty and no write in flight; used for fence and drain.
REQ-012 mem_we_o  output  1  write request to data RAM.
REQ-013 mem_addr_o  output  32  word-aligned write address.
REQ-014 mem_wdata_o  output  32  lane-replicated write data.
REQ-015 mem_be_o  output  4  byte enables; bit n selects bits [8n+7:8n].
REQ-016 mem_ack_i  input  1  RAM accepted the current write.

Function
REQ-017 A request is accepted at a rising clk edge when all of the following hold: valid_i=1, itype_i=`STYPE, stall_o=0, funct3 is legal and the address is aligned.
REQ-018 Legal funct3 values are `SB3 (000), `SH3 (001) and `SW3 (010); any other value is dropped with no flag raised.
REQ-019 Store formatting:
- SB: wdata={4{pass_in[7:0]}}, be=4'b0001<<y_in[1:0].
- SH: wdata={2{pass_in[15:0]}}, be=y_in[1] ? 4'b1100 : 4'b0011.
- SW: wdata=pass_in, be=4'b1111.
- All widths: addr={y_in[31:2],2'b00}.
REQ-020 A misaligned store (SH with y_in[0]=1, or SW with y_in[1:0]!=0) is not enqueued; misalign_o is driven high for exactly the next cycle.
REQ-021 The write buffer is an in-order FIFO holding {addr, wdata, be}; occupancy counts 0..DEPTH.
REQ-022 stall_o equals (count==DEPTH) and is decoded combinationally from the registered count.
REQ-023 Memory FSM states:
- IDLE: mem_we_o=0. Moves to WRITE on the first edge at which count>0.
- WRITE: mem_we_o=1, with mem_addr_o, mem_wdata_o and mem_be_o taken from the FIFO head and held stable until mem_ack_i=1 is sampled.
- On ack: pop the head; stay in WRITE if count after pop >0, otherwise return to IDLE.
REQ-024 The first write is issued one cycle after the accept edge; a single store with an immediate ack completes in 2 cycles.
REQ-025 Back-to-back writes: after each ack, mem_we_o stays high and the next head is presented with no bubble.
REQ-026 A push and a pop on the same edge leave count unchanged, and FIFO order is preserved.
REQ-027 When the buffer is full, a push in the same cycle as an ack is still refused, because stall_o is already high.
REQ-028 mem_ack_i is ignored in IDLE.
REQ-029 The read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-030 empty_o = (count==0) && state==IDLE.
REQ-031 Whenever mem_we_o=0, mem_addr_o, mem_wdata_o and mem_be_o are driven to 0.

Reset
REQ-032 Reset asynchronously clears all of the following:
- count and both pointers;
- FSM state to IDLE;
- mem_we_o, misalign_o and stall_o to 0;
- mem_addr_o, mem_wdata_o and mem_be_o to 0;
- empty_o to 1.
REQ-033 Reset asserted during WRITE abandons the in-flight and all buffered stores; mem_we_o falls without waiting for a clock edge.
REQ-034 The first accept after reset is sampled at the first rising edge at which reset is low.

Verification
REQ-035 SB, y_in=0x103, pass_in=0x12345678 -> mem_addr_o=0x100, wdata=0x78787878, be=4'b1000, mem_we_o rises one cycle after accept.
REQ-036 SH, y_in=0x202, pass_in=0xAABBCCDD -> addr=0x200, wdata=0xCCDDCCDD, be=4'b1100; SH at y_in=0x201 -> misalign_o pulses for one cycle, mem_we_o stays 0.
REQ-037 DEPTH=2, three SWs to 0x0, 0x4 and 0x8 on consecutive cycles with mem_ack_i=0:
- The third request sees stall_o=1.
- After acks, writes complete in order 0x0, 0x4, 0x8.
REQ-038 mem_ack_i held at 1 with four queued SWs -> mem_we_o stays high for four consecutive cycles, one pop per cycle, then empty_o=1.
REQ-039 Reset pulsed while in WRITE with 2 entries queued -> mem_we_o=0 immediately, empty_o=1, and no further writes after reset is released.
REQ-040 valid_i=1 with itype_i!=`STYPE, or with funct3=3'b011 -> no enqueue, misalign_o=0, count unchanged.

Source files
------------

// File: rtl/store_unit.sv
// Store unit: formats SB/SH/SW stores and queues them in an in-order write buffer that drains to data RAM.
// Latency: the first write is issued one cycle after the accept edge; a pop per cycle while mem_ack_i stays high.
// Backpressure: stall_o rises when the buffer holds DEPTH entries; the RAM holds a write until mem_ack_i.
module store_unit #(
    parameter int         DEPTH = 2,
    parameter logic [4:0] STYPE = 5'b01000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [4:0]  itype_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] y_in,
    input  logic [31:0] pass_in,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        empty_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] SB3 = 3'b000;
    localparam logic [2:0] SH3 = 3'b001;
    localparam logic [2:0] SW3 = 3'b010;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic            misalign_q;

    logic [31:0]     addr_mem  [DEPTH];
    logic [31:0]     wdata_mem [DEPTH];
    logic [3:0]      be_mem    [DEPTH];

    logic [2:0]      funct3;
    logic            legal, misal, is_store, push, pop;
    logic [31:0]     fmt_wdata;
    logic [3:0]      fmt_be;

    wire unused_ir = &{1'b0, ir_i[31:15], ir_i[11:0]};

    assign funct3 = ir_i[14:12];

    always_comb begin
        legal     = 1'b0;
        misal     = 1'b0;
        fmt_wdata = '0;
        fmt_be    = '0;
        case (funct3)
            SB3: begin
                legal     = 1'b1;
                fmt_wdata = {4{pass_in[7:0]}};
                fmt_be    = 4'b0001 << y_in[1:0];
            end
            SH3: begin
                legal     = 1'b1;
                misal     = y_in[0];
                fmt_wdata = {2{pass_in[15:0]}};
                fmt_be    = y_in[1] ? 4'b1100 : 4'b0011;
            end
            SW3: begin
                legal     = 1'b1;
                misal     = |y_in[1:0];
                fmt_wdata = pass_in;
                fmt_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // A stalled request is held by the pipeline, so it is neither accepted nor flagged.
    assign is_store  = valid_i && (itype_i == STYPE) && !stall_o;
    assign push      = is_store && legal && !misal;
    assign pop       = (state == WRITE) && mem_ack_i;
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            state      <= IDLE;
            misalign_q <= 1'b0;
        end else begin
            count      <= count_nxt;
            state      <= state_nxt;
            misalign_q <= is_store && legal && misal;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr]  <= {y_in[31:2], 2'b00};
            wdata_mem[wr_ptr] <= fmt_wdata;
            be_mem[wr_ptr]    <= fmt_be;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = WRITE;
            WRITE:   if (pop && (count_nxt == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from the state register so reset drops mem_we_o without a clock edge.
    assign mem_we_o    = (state == WRITE);
    assign mem_addr_o  = mem_we_o ? addr_mem[rd_ptr]  : 32'h0;
    assign mem_wdata_o = mem_we_o ? wdata_mem[rd_ptr] : 32'h0;
    assign mem_be_o    = mem_we_o ? be_mem[rd_ptr]    : 4'h0;
    assign stall_o     = (count == CW'(DEPTH));
    assign empty_o     = (count == '0) && (state == IDLE);
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: a DEPTH=2 and a DEPTH=4 instance share data inputs; each has its own valid and ack.
// Expected writes are queued at issue time and popped by a monitor whenever a write is acknowledged.
module tb_store_unit;

    localparam logic [4:0] ST = 5'b01000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  itype;
    logic [31:0] ir, y_in, pass_in;
    logic        v2, ack2, v4, ack4;

    logic        stall2, mis2, empty2, we2;
    logic [31:0] addr2, wd2;
    logic [3:0]  be2;
    logic        stall4, mis4, empty4, we4;
    logic [31:0] addr4, wd4;
    logic [3:0]  be4;

    int errors = 0;
    int checks = 0;

    logic [67:0] exp2 [$];
    logic [67:0] exp4 [$];

    always #5 clk = ~clk;

    store_unit #(.DEPTH(2), .STYPE(ST)) u_dut2 (
        .clk(clk), .reset(reset), .valid_i(v2), .itype_i(itype), .ir_i(ir),
        .y_in(y_in), .pass_in(pass_in), .stall_o(stall2), .misalign_o(mis2),
        .empty_o(empty2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wd2),
        .mem_be_o(be2), .mem_ack_i(ack2)
    );

    store_unit #(.DEPTH(4), .STYPE(ST)) u_dut4 (
        .clk(clk), .reset(reset), .valid_i(v4), .itype_i(itype), .ir_i(ir),
        .y_in(y_in), .pass_in(pass_in), .stall_o(stall4), .misalign_o(mis4),
        .empty_o(empty4), .mem_we_o(we4), .mem_addr_o(addr4), .mem_wdata_o(wd4),
        .mem_be_o(be4), .mem_ack_i(ack4)
    );

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: a write completes at the next rising edge when mem_we_o and mem_ack_i are both high.
    always @(negedge clk) begin
        if (we2 && ack2) begin
            if (exp2.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr2_unexpected actual=%0h required=none", {addr2, wd2, be2});
            end else chk("wr2_data", {addr2, wd2, be2}, exp2.pop_front());
        end else if (!we2) chk("wr2_idle_zero", {addr2, wd2, be2}, 68'h0);
        if (we4 && ack4) begin
            if (exp4.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr4_unexpected actual=%0h required=none", {addr4, wd4, be4});
            end else chk("wr4_data", {addr4, wd4, be4}, exp4.pop_front());
        end else if (!we4) chk("wr4_idle_zero", {addr4, wd4, be4}, 68'h0);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input bit d4, input logic [4:0] it, input logic [2:0] f3,
                           input logic [31:0] y, input logic [31:0] p);
        itype   = it;
        ir      = {17'h0, f3, 12'h0};
        y_in    = y;
        pass_in = p;
        if (d4) v4 = 1'b1; else v2 = 1'b1;
    endtask

    task automatic wait_idle(input bit d4, input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (d4 ? (empty4 && exp4.size() == 0) : (empty2 && exp2.size() == 0)) begin
                done = 1'b1;
                break;
            end
            step;
        end
        chk(nm, 68'(done), 68'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        bit         s;
        int         n;

        reset = 1'b1; v2 = 0; v4 = 0; ack2 = 0; ack4 = 0;
        itype = '0; ir = '0; y_in = '0; pass_in = '0;
        #12;
        chk("rst_we",       68'(we2),    68'h0);
        chk("rst_stall",    68'(stall2), 68'h0);
        chk("rst_misalign", 68'(mis2),   68'h0);
        chk("rst_empty2",   68'(empty2), 68'h1);
        chk("rst_empty4",   68'(empty4), 68'h1);
        chk("rst_bus",      {addr2, wd2, be2}, 68'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // SB at 0x103
        ack2 = 1'b1;
        exp2.push_back({32'h100, 32'h78787878, 4'b1000});
        present(0, ST, 3'b000, 32'h103, 32'h12345678);
        step; v2 = 0;
        chk("sb_we_accept_edge", 68'(we2),    68'h0);
        chk("sb_not_empty",      68'(empty2), 68'h0);
        step;
        chk("sb_we_rise", 68'(we2), 68'h1);
        step;
        chk("sb_done_2cyc", 68'(empty2), 68'h1);

        // SH aligned, then SH misaligned
        exp2.push_back({32'h200, 32'hCCDDCCDD, 4'b1100});
        present(0, ST, 3'b001, 32'h202, 32'hAABBCCDD);
        step; v2 = 0;
        wait_idle(0, "sh_drain");
        present(0, ST, 3'b001, 32'h201, 32'hAABBCCDD);
        step; v2 = 0;
        chk("sh_mis_pulse", 68'(mis2), 68'h1);
        chk("sh_mis_no_we", 68'(we2),  68'h0);
        step;
        chk("sh_mis_one_cycle", 68'(mis2),   68'h0);
        chk("sh_mis_no_we2",    68'(we2),    68'h0);
        chk("sh_mis_empty",     68'(empty2), 68'h1);

        // Non-store itype, illegal funct3, misaligned SW
        present(0, 5'b00100, 3'b010, 32'h300, 32'hDEADBEEF);
        step; v2 = 0;
        chk("itype_no_mis",   68'(mis2),   68'h0);
        chk("itype_no_enq",   68'(empty2), 68'h1);
        present(0, ST, 3'b011, 32'h300, 32'hDEADBEEF);
        step; v2 = 0;
        chk("f3_011_no_mis",  68'(mis2),   68'h0);
        chk("f3_011_no_enq",  68'(empty2), 68'h1);
        step;
        chk("drop_no_we",     68'(we2),    68'h0);
        present(0, ST, 3'b010, 32'h306, 32'h01020304);
        step; v2 = 0;
        chk("sw_mis_pulse",   68'(mis2),   68'h1);
        chk("sw_mis_no_enq",  68'(empty2), 68'h1);
        step;

        // DEPTH=2 fill: third request stalls, held until accepted, order preserved
        ack2 = 1'b0;
        exp2.push_back({32'h0, 32'h11111111, 4'b1111});
        present(0, ST, 3'b010, 32'h0, 32'h11111111);
        step;
        exp2.push_back({32'h4, 32'h22222222, 4'b1111});
        present(0, ST, 3'b010, 32'h4, 32'h22222222);
        step;
        exp2.push_back({32'h8, 32'h33333333, 4'b1111});
        present(0, ST, 3'b010, 32'h8, 32'h33333333);
        chk("third_sees_stall", 68'(stall2), 68'h1);
        step;
        chk("full_still_stall", 68'(stall2), 68'h1);
        chk("full_we_held",     {63'h0, we2, addr2[3:0]}, {63'h0, 1'b1, 4'h0});
        ack2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s = stall2;
            step;
            if (!s) break;
        end
        v2 = 0;
        wait_idle(0, "fill_drain");

        // DEPTH=4: four queued SWs drain back-to-back under a held ack
        ack4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp4.push_back({32'h10 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i), 4'b1111});
            present(1, ST, 3'b010, 32'h10 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i));
            step;
        end
        v4 = 0;
        chk("d4_full_stall", 68'(stall4), 68'h1);
        ack4 = 1'b1;
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            pat = {pat[6:0], we4};
            step;
        end
        chk("d4_we_4_cycles", 68'(pat),    68'hF0);
        chk("d4_empty_after", 68'(empty4), 68'h1);
        chk("d4_all_popped",  68'(exp4.size()), 68'h0);

        // Reset pulsed in WRITE with two entries queued
        ack2 = 1'b0;
        present(0, ST, 3'b010, 32'h40, 32'h55555555);
        step;
        present(0, ST, 3'b010, 32'h44, 32'h66666666);
        step; v2 = 0;
        chk("rw_we_before", 68'(we2), 68'h1);
        #2 reset = 1'b1;
        #1;
        chk("rw_we_async",   68'(we2),    68'h0);
        chk("rw_empty",      68'(empty2), 68'h1);
        chk("rw_stall",      68'(stall2), 68'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        ack2 = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (we2) n++;
            step;
        end
        chk("rw_no_writes", 68'(n),      68'h0);
        chk("rw_empty_end", 68'(empty2), 68'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
